// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU issue arbiter: op codes, FSM states and the op legality check.
package alu_arb_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLL = 3'b100,
    SRL = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // 3'b110 and 3'b111 have no ALU meaning.
  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
    return !(op[2] & op[1]);
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request at or after ptr wins,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  localparam int SW = ID_W + 1;

  logic [SW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit so ptr+k cannot overflow before the wrap.
      cand = {1'b0, ptr} + SW'(k);
      if (cand >= SW'(NUM_REQ)) begin
        cand = cand - SW'(NUM_REQ);
      end
      if (!any && req[cand[ID_W-1:0]]) begin
        any                    = 1'b1;
        grant[cand[ID_W-1:0]]  = 1'b1;
        idx                    = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one external ALU between NUM_REQ requesters with round-robin issue and a tagged
// response channel. Define ALU_ISSUE_ARBITER_PERF_EN to add perf_issued/perf_stall counters.
module alu_issue_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DATA_W  = 32,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]    req_op1,
  input  logic [NUM_REQ*DATA_W-1:0]    req_op2,
  input  logic [NUM_REQ*ALU_OP_W-1:0]  req_ctrl,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_W-1:0]            resp_result,
  output logic [ID_W-1:0]              resp_id,
  output logic                         resp_err,
  output logic [DATA_W-1:0]            alu_operand1,
  output logic [DATA_W-1:0]            alu_operand2,
  output logic [ALU_OP_W-1:0]          alu_control,
  input  logic [DATA_W-1:0]            alu_result,
  output logic                         busy
`ifdef ALU_ISSUE_ARBITER_PERF_EN
  ,
  output logic [31:0]                  perf_issued,
  output logic [31:0]                  perf_stall
`endif
);

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       issue_id_q, issue_id_d;
  logic [DATA_W-1:0]     op1_q, op1_d, op2_q, op2_d;
  logic [ALU_OP_W-1:0]   ctrl_q, ctrl_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]     resp_result_q, resp_result_d;
  logic [ID_W-1:0]       resp_id_q, resp_id_d;
  logic                  resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       win_idx;
  logic                  any_req;
  logic                  window;
  logic                  accept;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx),
    .any   (any_req)
  );

  // A response handshake in RESP frees the ALU in the same cycle, so a new op may issue.
  always_comb begin
    window    = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
    accept    = rst_n && window && any_req;
    req_ready = accept ? grant : '0;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    issue_id_d    = issue_id_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    ctrl_d        = ctrl_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_id_d     = resp_id_q;
    resp_err_d    = resp_err_q;

    if (accept) begin
      op1_d      = req_op1[win_idx*DATA_W +: DATA_W];
      op2_d      = req_op2[win_idx*DATA_W +: DATA_W];
      ctrl_d     = req_ctrl[win_idx*ALU_OP_W +: ALU_OP_W];
      issue_id_d = win_idx;
      ptr_d      = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        resp_valid_d  = 1'b1;
        resp_err_d    = !is_legal_op(ctrl_q);
        resp_result_d = is_legal_op(ctrl_q) ? alu_result : '0;
        resp_id_d     = issue_id_q;
        state_d       = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = accept ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      issue_id_q    <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      ctrl_q        <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_id_q     <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      issue_id_q    <= issue_id_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      ctrl_q        <= ctrl_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_id_q     <= resp_id_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
  assign alu_control  = ctrl_q;
  assign resp_valid   = resp_valid_q;
  assign resp_result  = resp_result_q;
  assign resp_id      = resp_id_q;
  assign resp_err     = resp_err_q;
  assign busy         = (state_q != IDLE);

`ifdef ALU_ISSUE_ARBITER_PERF_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept) perf_issued_q <= perf_issued_q + 32'd1;
      if ((|req_valid) && !accept) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a behavioural ALU on the alu_* ports.
module tb_alu_issue_arbiter;
  import alu_arb_pkg::*;

  localparam int NR = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*DW-1:0] req_op1, req_op2;
  logic [NR*3-1:0] req_ctrl;
  logic            resp_valid, resp_ready;
  logic [DW-1:0]   resp_result;
  logic [0:0]      resp_id;
  logic            resp_err;
  logic [DW-1:0]   alu_operand1, alu_operand2, alu_result;
  logic [2:0]      alu_control;
  logic            busy;
`ifdef ALU_ISSUE_ARBITER_PERF_EN
  logic [31:0]     perf_issued, perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_ctrl     (req_ctrl),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_id      (resp_id),
    .resp_err     (resp_err),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .busy         (busy)
`ifdef ALU_ISSUE_ARBITER_PERF_EN
    ,
    .perf_issued  (perf_issued),
    .perf_stall   (perf_stall)
`endif
  );

  // External ALU; illegal codes return garbage so a leak into resp_result is visible.
  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_operand1 + alu_operand2;
      3'b001:  alu_result = alu_operand1 - alu_operand2;
      3'b010:  alu_result = alu_operand1 & alu_operand2;
      3'b011:  alu_result = alu_operand1 | alu_operand2;
      3'b100:  alu_result = alu_operand1 << alu_operand2[4:0];
      3'b101:  alu_result = alu_operand1 >> alu_operand2[4:0];
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    req_op1[i*DW +: DW] = a;
    req_op2[i*DW +: DW] = b;
    req_ctrl[i*3 +: 3]  = c;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; resp_ready = 1'b1; req_valid = 2'b11;
    set_req(0, ADD, 32'd1, 32'd1);
    set_req(1, ADD, 32'd2, 32'd2);
    tick(); tick();
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset.req_ready got=%b exp=00", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset.resp_valid got=%b exp=0", resp_valid); end
    n_checks++; if (resp_result !== 32'd0) begin n_fail++; $display("FAIL reset.resp_result got=%h exp=0", resp_result); end
    n_checks++; if (resp_id !== 1'b0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL reset.resp_id_err got=%b/%b exp=0/0", resp_id, resp_err); end
    n_checks++; if (alu_operand1 !== 32'd0 || alu_operand2 !== 32'd0 || alu_control !== 3'd0) begin n_fail++; $display("FAIL reset.alu got=%h/%h/%b exp=0/0/000", alu_operand1, alu_operand2, alu_control); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset.busy got=%b exp=0", busy); end
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_single;
    set_req(0, ADD, 32'd5, 32'd7);
    req_valid = 2'b01; resp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single.req_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (alu_operand1 !== 32'd5 || alu_operand2 !== 32'd7 || alu_control !== 3'b000) begin n_fail++; $display("FAIL single.alu got=%0d/%0d/%b exp=5/7/000", alu_operand1, alu_operand2, alu_control); end
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single.exec got valid=%b busy=%b exp 0/1", resp_valid, busy); end
    tick();
    n_checks++; if (resp_valid !== 1'b1 || resp_result !== 32'd12 || resp_id !== 1'b0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL single.resp got v=%b r=%0d id=%0d e=%b exp 1/12/0/0", resp_valid, resp_result, resp_id, resp_err); end
    $display("txn single id=%0d result=%0d", resp_id, resp_result);
    tick();
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single.idle got valid=%b busy=%b exp 0/0", resp_valid, busy); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  exp_gnt;
    logic [31:0] exp_res;
    logic [0:0]  exp_id;
    do_reset();
    set_req(0, SUB, 32'd10, 32'd3);
    set_req(1, OR, 32'h0000_00F0, 32'h0000_000F);
    req_valid = 2'b11; resp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_id  = 1'(i % 2);
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_res = (i % 2 == 0) ? 32'd7 : 32'h0000_00FF;
      n_checks++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL b2b.grant[%0d] got=%b exp=%b", i, req_ready, exp_gnt); end
      tick();
      n_checks++; if (req_ready !== 2'b00 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b.exec[%0d] got ready=%b valid=%b exp 00/0", i, req_ready, resp_valid); end
      tick();
      n_checks++; if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_result !== exp_res) begin n_fail++; $display("FAIL b2b.resp[%0d] got v=%b id=%0d r=%h exp 1/%0d/%h", i, resp_valid, resp_id, resp_result, exp_id, exp_res); end
      $display("txn b2b id=%0d result=%h", resp_id, resp_result);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure;
    set_req(0, ADD, 32'd1, 32'd2);
    set_req(1, AND, 32'h0000_00FF, 32'h0000_003C);
    req_valid = 2'b01; resp_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    tick();
    req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (req_ready !== 2'b00 || resp_valid !== 1'b1 || resp_result !== 32'd3 || resp_id !== 1'b0) begin n_fail++; $display("FAIL bp.hold[%0d] got rdy=%b v=%b r=%0d id=%0d exp 00/1/3/0", i, req_ready, resp_valid, resp_result, resp_id); end
      tick();
    end
    $display("txn bp id=%0d result=%0d", resp_id, resp_result);
    resp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp.release_grant got=%b exp=10", req_ready); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (resp_valid !== 1'b0 || alu_operand1 !== 32'hFF || alu_control !== 3'b010) begin n_fail++; $display("FAIL bp.reissue got v=%b op1=%h ctl=%b exp 0/ff/010", resp_valid, alu_operand1, alu_control); end
    tick();
    n_checks++; if (resp_valid !== 1'b1 || resp_result !== 32'h3C || resp_id !== 1'b1) begin n_fail++; $display("FAIL bp.resp2 got v=%b r=%h id=%0d exp 1/3c/1", resp_valid, resp_result, resp_id); end
    $display("txn bp id=%0d result=%h", resp_id, resp_result);
    tick();
  endtask

  task automatic test_illegal;
    set_req(0, 3'b111, 32'd9, 32'd9);
    req_valid = 2'b01; resp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_result !== 32'd0) begin n_fail++; $display("FAIL illegal.resp got v=%b e=%b r=%h exp 1/1/0", resp_valid, resp_err, resp_result); end
    $display("txn illegal id=%0d err=%b", resp_id, resp_err);
    set_req(0, SLL, 32'd1, 32'd4);
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL illegal.next_grant got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_result !== 32'd16) begin n_fail++; $display("FAIL illegal.legal_after got v=%b e=%b r=%0d exp 1/0/16", resp_valid, resp_err, resp_result); end
    $display("txn legal id=%0d result=%0d", resp_id, resp_result);
    set_req(1, 3'b110, 32'd3, 32'd3);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    n_checks++; if (resp_err !== 1'b1 || resp_result !== 32'd0 || resp_id !== 1'b1) begin n_fail++; $display("FAIL illegal.op110 got e=%b r=%h id=%0d exp 1/0/1", resp_err, resp_result, resp_id); end
    $display("txn illegal id=%0d err=%b", resp_id, resp_err);
    tick();
  endtask

  task automatic test_reset_mid;
    set_req(0, ADD, 32'd2, 32'd3);
    set_req(1, ADD, 32'd4, 32'd4);
    req_valid = 2'b01; resp_ready = 1'b1;
    tick();
    rst_n = 1'b0; req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rstmid.ready_in_reset got=%b exp=00", req_ready); end
    tick();
    rst_n = 1'b1; req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid.no_resp[%0d] got v=%b busy=%b exp 0/0", i, resp_valid, busy); end
      tick();
    end
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid.ptr_reset got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    n_checks++; if (resp_id !== 1'b0 || resp_result !== 32'd5) begin n_fail++; $display("FAIL rstmid.resp got id=%0d r=%0d exp 0/5", resp_id, resp_result); end
    $display("txn rstmid id=%0d result=%0d", resp_id, resp_result);
    tick();
  endtask

`ifdef ALU_ISSUE_ARBITER_PERF_EN
  task automatic test_perf;
    do_reset();
    n_checks++; if (perf_issued !== 32'd0 || perf_stall !== 32'd0) begin n_fail++; $display("FAIL perf.reset got=%0d/%0d exp 0/0", perf_issued, perf_stall); end
    set_req(0, ADD, 32'd1, 32'd1);
    req_valid = 2'b01; resp_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    req_valid = 2'b00;
    n_checks++; if (perf_issued !== 32'd4 || perf_stall !== 32'd3) begin n_fail++; $display("FAIL perf.counts got issued=%0d stall=%0d exp 4/3", perf_issued, perf_stall); end
    $display("txn perf issued=%0d stall=%0d", perf_issued, perf_stall);
    tick(); tick();
  endtask
`endif

  initial begin
    req_valid = '0; req_op1 = '0; req_op2 = '0; req_ctrl = '0;
    resp_ready = 1'b1; rst_n = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_mid();
`ifdef ALU_ISSUE_ARBITER_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
